// File: rtl/apb_master.sv
// APB master: one command in, one APB transfer out, one response back.
// Optional ACCESS-wait timeout compiled in with `define APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a command; APB bus idle
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high, waiting on pready
// RESP   | response held until rsp_ready_i
module apb_master #(
  parameter int BUS_WIDTH      = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = BUS_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  tmo_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  // Down-counter loaded in SETUP; terminal count on the last allowed wait cycle.
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == ACCESS) && (tmo_q == '0);

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == SETUP) begin
      tmo_d = TMO_LOAD;
    end else if (state_q == ACCESS) begin
      tmo_d = (pready_i || tmo_hit) ? '0 : tmo_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  // No timeout: ACCESS ends only on pready_i; the term below folds to 0.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          pwrite_d = cmd_write_i;
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
          pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          state_d     = RESP;
        end else if (tmo_hit) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Reset is folded in so the block never advertises readiness while held.
  assign cmd_ready_o = rst_ni && (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master; expected responses are queued at issue
// and popped when the DUT presents them.
module tb_apb_master;
  localparam int BW  = 16;
  localparam int AW  = 16;
  localparam int SW  = 2;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [BW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [BW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready, pslverr;
  logic [BW-1:0] prdata;
  logic          prdata_ovr_en;
  logic [BW-1:0] prdata_ovr;

  typedef struct packed {
    logic [BW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Responder returns an address-derived word unless a test overrides it.
  assign prdata = prdata_ovr_en ? prdata_ovr : (paddr ^ 16'h5A5A);

  apb_master #(
    .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
  );

  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] d, input logic [SW-1:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0; pready = 1'b1;
    pslverr = 1'b0; prdata_ovr_en = 1'b0; prdata_ovr = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
    n_checks++; if ({busy, psel, penable, pwrite, rsp_valid, rsp_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b want=000000", {busy, psel, penable, pwrite, rsp_valid, rsp_err}); end
    n_checks++; if ({paddr, pwdata, pstrb, rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h want=0", {paddr, pwdata, pstrb, rsp_rdata}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait;
    exp_t e;
    pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_idle_ready got=%b want=1", cmd_ready); end
    issue(1'b1, 16'h0010, 16'hBEEF, 2'b11);
    sb_q.push_back('{rdata: 16'h0000, err: 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if ({psel, penable, pwrite, cmd_ready, busy} !== 5'b10101) begin
      n_fail++; $display("FAIL wr_setup_ctrl got=%b want=10101", {psel, penable, pwrite, cmd_ready, busy}); end
    n_checks++; if ({paddr, pwdata, pstrb} !== {16'h0010, 16'hBEEF, 2'b11}) begin
      n_fail++; $display("FAIL wr_setup_bus got=%h/%h/%b want=0010/beef/11", paddr, pwdata, pstrb); end
    @(negedge clk);
    n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL wr_access got=%b want=11", {psel, penable}); end
    @(negedge clk);
    n_checks++; if ({rsp_valid, psel, penable} !== 3'b100) begin
      n_fail++; $display("FAIL wr_resp_ctrl got=%b want=100", {rsp_valid, psel, penable}); end
    e = sb_q.pop_front();
    n_checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
      n_fail++; $display("FAIL wr_resp_data got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      n_fail++; $display("FAIL wr_back_idle got=%b want=010", {rsp_valid, cmd_ready, busy}); end
  endtask

  task automatic test_read_wait;
    exp_t e;
    int   en_cnt = 0;
    logic stable = 1'b1;
    pready = 1'b0; prdata_ovr_en = 1'b1; prdata_ovr = 16'hDEAD;
    issue(1'b0, 16'h0004, 16'hFFFF, 2'b11);
    sb_q.push_back('{rdata: 16'h1234, err: 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (penable) begin
        en_cnt++;
        if ({paddr, pwrite, pwdata, pstrb} !== {16'h0004, 1'b0, 16'h0000, 2'b00}) stable = 1'b0;
        if (en_cnt >= 4) begin pready = 1'b1; prdata_ovr = 16'h1234; end
      end
    end
    n_checks++; if (en_cnt !== 4) begin n_fail++; $display("FAIL rd_penable_cycles got=%0d want=4", en_cnt); end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL rd_bus_stable got=%b want=1", stable); end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid got=%b want=1", rsp_valid); end
    e = sb_q.pop_front();
    n_checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
      n_fail++; $display("FAIL rd_resp_data got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    prdata_ovr_en = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_slverr;
    exp_t e;
    pready = 1'b1; pslverr = 1'b1;
    issue(1'b1, 16'h0020, 16'h0001, 2'b01);
    sb_q.push_back('{rdata: 16'h0000, err: 1'b1});
    @(negedge clk);
    issue(1'b0, 16'h0077, 16'h5555, 2'b10);
    repeat (2) @(negedge clk);
    e = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if ({rsp_valid, cmd_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, e.err, e.rdata}) begin
        n_fail++; $display("FAIL err_hold%0d got=%b/%b/%b/%h want=1/0/%b/%h", k,
                           rsp_valid, cmd_ready, rsp_err, rsp_rdata, e.err, e.rdata); end
      n_checks++; if (paddr !== 16'h0020) begin n_fail++; $display("FAIL err_addr_ignored%0d got=%h want=0020", k, paddr); end
      @(negedge clk);
    end
    cmd_valid = 1'b0; pslverr = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL err_back_idle got=%b want=10", {cmd_ready, busy}); end
  endtask

  task automatic test_reset_mid_access;
    logic seen = 1'b0;
    pready = 1'b0;
    issue(1'b0, 16'h0008, 16'h0000, 2'b00);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({psel, penable, busy, cmd_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_async got=%b want=0000", {psel, penable, busy, cmd_ready}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || psel) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp got=%b want=0", seen); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_timeout;
    exp_t e;
    int   acc = 0;
    pready = 1'b0;
    issue(1'b0, 16'h0030, 16'h0000, 2'b00);
`ifdef APB_MASTER_TIMEOUT_EN
    sb_q.push_back('{rdata: 16'h0000, err: 1'b1});
`else
    sb_q.push_back('{rdata: 16'h0030 ^ 16'h5A5A, err: 1'b0});
`endif
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (penable) acc++;
    end
`ifdef APB_MASTER_TIMEOUT_EN
    n_checks++; if (acc !== TMO) begin n_fail++; $display("FAIL tmo_access_cycles got=%0d want=%0d", acc, TMO); end
`else
    n_checks++; if (acc !== 100) begin n_fail++; $display("FAIL tmo_wait_forever got=%0d want=100", acc); end
    pready = 1'b1;
    @(negedge clk);
`endif
    n_checks++; if ({rsp_valid, psel, penable} !== 3'b100) begin
      n_fail++; $display("FAIL tmo_resp_ctrl got=%b want=100", {rsp_valid, psel, penable}); end
    e = sb_q.pop_front();
    n_checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
      n_fail++; $display("FAIL tmo_resp_data got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    pready = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_t          e;
    int            issued = 0, got = 0, last_rise = -1;
    logic          prev_psel = 1'b0;
    logic [AW-1:0] a;
    pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b1; prdata_ovr_en = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      if (psel && !prev_psel) begin
        if (last_rise >= 0) begin
          n_checks++; if (cyc - last_rise !== 4) begin
            n_fail++; $display("FAIL b2b_interval got=%0d want=4", cyc - last_rise); end
        end
        last_rise = cyc;
      end
      prev_psel = psel;
      if (rsp_valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_rsp got=%h want=none", rsp_rdata);
        end else begin
          e = sb_q.pop_front();
          if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            n_fail++; $display("FAIL b2b_rsp%0d got=%h/%b want=%h/%b", got, rsp_rdata, rsp_err, e.rdata, e.err); end
        end
        got++;
      end
      if (cmd_ready && issued < 6) begin
        a = 16'h0100 + 16'(issued * 4);
        issue(issued[0] == 1'b0, a, 16'h1000 + 16'(issued), 2'b11);
        if (issued[0] == 1'b0) sb_q.push_back('{rdata: 16'h0000, err: 1'b0});
        else                   sb_q.push_back('{rdata: a ^ 16'h5A5A, err: 1'b0});
        issued++;
      end else if (cmd_ready) begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d want=6", got); end
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover got=%0d want=0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_reset_mid_access();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
